// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the REG_EIGHT round-robin arbiter.
// Op encoding matches the per-requester ARB_OP slices.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ,
        OP_LOAD,
        OP_CLEAR,
        OP_SET
    } reg_op_t;

    typedef enum {
        ST_IDLE,
        ST_ISSUE,
        ST_CHECK
    } arb_state_t;

    localparam logic [7:0] SET_VAL = 8'h01;
    localparam logic [7:0] CLR_VAL = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    localparam int SW = IW + 1;

    logic [SW-1:0] slot;

    // Scan from the far end back toward ptr so the nearest requester wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        slot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + SW'(k);
            if (slot >= SW'(N_REQ)) begin
                slot = slot - SW'(N_REQ);
            end
            if (req[slot[IW-1:0]]) begin
                idx = slot[IW-1:0];
                any = 1'b1;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_eight_arbiter.sv
// Round-robin owner of the shared REG_EIGHT register: one strobe per
// transaction, then a readback compare reported with a DONE pulse.
import reg_arb_pkg::*;

module reg_eight_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                     ARB_CLK,
    input  logic                     ARB_RST,
    input  logic [N_REQ-1:0]         ARB_REQ,
    input  logic [2*N_REQ-1:0]       ARB_OP,
    input  logic [DW*N_REQ-1:0]      ARB_DATA,
    output logic [N_REQ-1:0]         ARB_GNT,
    output logic [N_REQ-1:0]         ARB_DONE,
    output logic [DW-1:0]            ARB_RDATA,
    output logic                     ARB_ERR,
    output logic                     ARB_BUSY,
    output logic [$clog2(N_REQ)-1:0] ARB_OWNER,
    output logic                     REG_E,
    output logic                     REG_C,
    output logic                     REG_SET,
    output logic [DW-1:0]            REG_D,
    input  logic [DW-1:0]            REG_Q
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx_q;
    reg_op_t         op_q;
    logic [DW-1:0]   data_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    reg_op_t          pick_op;
    logic [DW-1:0]    pick_data;
    logic [DW-1:0]    exp_val;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req (ARB_REQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Op and data of the requester that would win this cycle.
    always_comb begin
        pick_op   = reg_op_t'(ARB_OP[2*int'(pick_idx) +: 2]);
        pick_data = ARB_DATA[DW*int'(pick_idx) +: DW];
    end

    // Value the register should hold after the latched op; READ cannot err.
    always_comb begin
        exp_val = REG_Q;
        unique case (op_q)
            OP_LOAD:  exp_val = data_q;
            OP_CLEAR: exp_val = DW'(CLR_VAL);
            OP_SET:   exp_val = DW'(SET_VAL);
            default:  exp_val = REG_Q;
        endcase
    end

    // Transaction FSM: grant and strobe, let the register settle, read back.
    always_ff @(posedge ARB_CLK) begin
        if (ARB_RST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            idx_q     <= '0;
            op_q      <= OP_READ;
            data_q    <= '0;
            ARB_GNT   <= '0;
            ARB_DONE  <= '0;
            ARB_RDATA <= '0;
            ARB_ERR   <= 1'b0;
            ARB_BUSY  <= 1'b0;
            ARB_OWNER <= '0;
            REG_E     <= 1'b0;
            REG_C     <= 1'b0;
            REG_SET   <= 1'b0;
            REG_D     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ARB_DONE <= '0;
                    if (pick_any) begin
                        state     <= ST_ISSUE;
                        idx_q     <= pick_idx;
                        op_q      <= pick_op;
                        data_q    <= pick_data;
                        ARB_GNT   <= pick_gnt;
                        ARB_OWNER <= pick_idx;
                        ARB_BUSY  <= 1'b1;
                        REG_D     <= pick_data;
                        REG_E     <= (pick_op == OP_LOAD);
                        REG_C     <= (pick_op == OP_CLEAR);
                        REG_SET   <= (pick_op == OP_SET);
                    end
                end
                ST_ISSUE: begin
                    state   <= ST_CHECK;
                    ARB_GNT <= '0;
                    REG_E   <= 1'b0;
                    REG_C   <= 1'b0;
                    REG_SET <= 1'b0;
                end
                ST_CHECK: begin
                    state     <= ST_IDLE;
                    ARB_RDATA <= REG_Q;
                    ARB_ERR   <= (REG_Q != exp_val);
                    ARB_DONE  <= N_REQ'(1) << idx_q;
                    ARB_BUSY  <= 1'b0;
                    ptr       <= (idx_q == IW'(N_REQ - 1)) ? '0
                                                           : idx_q + 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
